// File: rtl/fetch_stage_pkg.sv
// Shared fetch/decode definitions: instruction format constants and the IF/ID payload.
package fetch_stage_pkg;

    localparam int unsigned INSTR_W   = 32;
    localparam int unsigned OPCODE_W  = 6;
    localparam int unsigned OPCODE_LSB = 26;

    localparam logic [INSTR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0000;

    // IF/ID pipeline register payload
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [INSTR_W-1:0] pc4;
        logic               valid;
    } ifid_t;

    localparam ifid_t IFID_BUBBLE = '{instr: NOP_INSTR, pc4: 32'h0, valid: 1'b0};

    // Primary opcode field of a MIPS instruction word
    function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[INSTR_W-1:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: flush inserts a bubble, hold freezes the contents.
module fetch_stage_ifid_reg
    import fetch_stage_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  hold,
    input  logic  flush,
    input  ifid_t d,
    output ifid_t q
);

    // Flush outranks hold so a squashed wrong-path fetch never survives a stall
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= IFID_BUBBLE;
        end else if (flush) begin
            q <= IFID_BUBBLE;
        end else if (!hold) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, misaligned-target flag, IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [INSTR_W-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned        IMEM_AW  = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [INSTR_W-1:0]   redirect_pc,
    output logic [IMEM_AW-1:0]   imem_addr,
    input  logic [INSTR_W-1:0]   imem_rdata,
    output logic [INSTR_W-1:0]   pc,
    output logic [INSTR_W-1:0]   ifid_instr,
    output logic [INSTR_W-1:0]   ifid_pc4,
    output logic                 ifid_valid,
    output logic [OPCODE_W-1:0]  ifid_opcode,
    output logic                 misalign_err
);

    localparam logic [INSTR_W-1:0] PC_STEP     = INSTR_W'(4);
    localparam logic [INSTR_W-1:0] RESET_PC_AL = {RESET_PC[INSTR_W-1:2], 2'b00};

    logic [INSTR_W-1:0] pc_q;
    logic [INSTR_W-1:0] pc_next;
    logic [INSTR_W-1:0] pc_plus4;
    logic               err_q;
    logic               err_next;
    ifid_t              ifid_d;
    ifid_t              ifid_q;

    // Sequential fetch address, wraps modulo 2^32
    assign pc_plus4 = pc_q + PC_STEP;

    // Next-PC select: redirect beats stall beats sequential fetch
    always_comb begin
        pc_next  = pc_q;
        err_next = err_q;
        if (redirect) begin
            pc_next = {redirect_pc[INSTR_W-1:2], 2'b00};
            if (redirect_pc[1:0] != 2'b00) begin
                err_next = 1'b1;
            end
        end else if (!stall) begin
            pc_next = pc_plus4;
        end
    end

    // PC and sticky misalignment flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q  <= RESET_PC_AL;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_next;
            err_q <= err_next;
        end
    end

    assign ifid_d = '{instr: imem_rdata, pc4: pc_plus4, valid: 1'b1};

    fetch_stage_ifid_reg u_ifid_reg (
        .clk   (clk),
        .rst   (rst),
        .hold  (stall),
        .flush (redirect),
        .d     (ifid_d),
        .q     (ifid_q)
    );

    assign imem_addr    = pc_q[IMEM_AW+1:2];
    assign pc           = pc_q;
    assign misalign_err = err_q;
    assign ifid_instr   = ifid_q.instr;
    assign ifid_pc4     = ifid_q.pc4;
    assign ifid_valid   = ifid_q.valid;
    assign ifid_opcode  = opcode_of(ifid_q.instr);

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random stall/redirect traffic against a reference model.
module tb_fetch_stage;

    localparam int unsigned DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic [5:0]  ifid_opcode;
    logic        misalign_err;

    logic [31:0] mem [DEPTH];

    // reference state
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    logic        e_valid;
    logic        e_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign imem_rdata = mem[imem_addr];

    fetch_stage #(.RESET_PC(32'h0000_0000), .IMEM_AW(10)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .pc           (pc),
        .ifid_instr   (ifid_instr),
        .ifid_pc4     (ifid_pc4),
        .ifid_valid   (ifid_valid),
        .ifid_opcode  (ifid_opcode),
        .misalign_err (misalign_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return mem[(a / 4) % DEPTH];
    endfunction

    task automatic model_reset();
        e_pc = 32'h0; e_instr = 32'h0; e_pc4 = 32'h0; e_valid = 1'b0; e_err = 1'b0;
    endtask

    // One clock edge of the fetch stage as described by its priority rules
    task automatic model_edge();
        if (!rst) begin
            model_reset();
        end else if (redirect) begin
            if (redirect_pc % 4 != 0) e_err = 1'b1;
            e_pc    = (redirect_pc / 4) * 4;
            e_instr = 32'h0;
            e_pc4   = 32'h0;
            e_valid = 1'b0;
        end else if (!stall) begin
            e_instr = word_of(e_pc);
            e_pc4   = e_pc + 32'd4;
            e_valid = 1'b1;
            e_pc    = e_pc + 32'd4;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"},        pc,                          e_pc);
        check({tag, ".imem_addr"}, 32'(imem_addr),              (e_pc / 4) % DEPTH);
        check({tag, ".instr"},     ifid_instr,                  e_instr);
        check({tag, ".pc4"},       ifid_pc4,                    e_pc4);
        check({tag, ".valid"},     32'(ifid_valid),             32'(e_valid));
        check({tag, ".opcode"},    32'(ifid_opcode),            e_instr >> 26);
        check({tag, ".err"},       32'(misalign_err),           32'(e_err));
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = $urandom;
        model_reset();
        #2 rst = 1'b0;
        #1 check_all("reset");

        // release reset away from the edge; first fetch is address 0
        @(posedge clk); #1 rst = 1'b1;
        check_all("rel");
        check("rel.addr0", 32'(imem_addr), 32'h0);

        // T2 sequential fetch
        cycle("seq1");
        check("seq1.A", ifid_instr, mem[0]);
        check("seq1.pc4", ifid_pc4, 32'd4);
        cycle("seq2");
        check("seq2.B", ifid_instr, mem[1]);

        // T3 two-cycle stall at pc=8
        stall = 1'b1;
        cycle("stall1");
        cycle("stall2");
        check("stall.pc", pc, 32'd8);
        check("stall.B", ifid_instr, mem[1]);
        check("stall.pc4", ifid_pc4, 32'd8);
        stall = 1'b0;
        cycle("seq3");
        check("seq3.C", ifid_instr, mem[2]);
        check("seq3.pc4", ifid_pc4, 32'd12);
        cycle("seq4");
        check("seq4.D", ifid_instr, mem[3]);
        check("seq4.pc4", ifid_pc4, 32'd16);

        // T4 redirect wins over stall
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
        cycle("rdst");
        check("rdst.pc", pc, 32'h40);
        check("rdst.valid", 32'(ifid_valid), 32'h0);
        stall = 1'b0; redirect = 1'b0;
        cycle("rdst2");
        check("rdst2.instr", ifid_instr, mem[16]);
        check("rdst2.pc4", ifid_pc4, 32'h44);

        // T5 misaligned target aligns down and sets sticky flag
        redirect = 1'b1; redirect_pc = 32'h26;
        cycle("mis");
        check("mis.pc", pc, 32'h24);
        check("mis.err", 32'(misalign_err), 32'h1);
        redirect = 1'b0;
        for (int i = 0; i < 3; i++) cycle("mis_run");
        check("mis.sticky", 32'(misalign_err), 32'h1);

        // back-to-back redirects keep IF/ID a bubble
        redirect = 1'b1; redirect_pc = 32'h100;
        cycle("rr1");
        redirect_pc = 32'h200;
        cycle("rr2");
        check("rr2.valid", 32'(ifid_valid), 32'h0);
        check("rr2.pc", pc, 32'h200);

        // T6 PC wrap at top of address space
        redirect_pc = 32'hFFFF_FFFC;
        cycle("wrap0");
        redirect = 1'b0;
        cycle("wrap1");
        check("wrap.pc4", ifid_pc4, 32'h0);
        check("wrap.pc", pc, 32'h0);
        check("wrap.addr", 32'(imem_addr), 32'h0);
        check("wrap.instr", ifid_instr, mem[DEPTH-1]);

        // random stall/redirect traffic
        for (int n = 0; n < 400; n++) begin
            stall       = ($urandom_range(0, 3) == 0);
            redirect    = ($urandom_range(0, 9) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? $urandom : (($urandom / 4) * 4);
            cycle("rnd");
        end

        // T1 async reset mid-run while stalled and redirecting
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h33;
        @(posedge clk);
        model_edge();
        #3 rst = 1'b0;
        model_reset();
        #1;
        check_all("arst");
        check("arst.pc", pc, 32'h0);
        check("arst.valid", 32'(ifid_valid), 32'h0);
        check("arst.instr", ifid_instr, 32'h0);
        check("arst.err", 32'(misalign_err), 32'h0);
        cycle("arst_hold");
        stall = 1'b0; redirect = 1'b0;
        rst = 1'b1;
        #1 check("arst.addr0", 32'(imem_addr), 32'h0);
        cycle("arst_f1");
        check("arst_f1.instr", ifid_instr, mem[0]);
        check("arst_f1.pc4", ifid_pc4, 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
